// File: rtl/instr_ptr_stack.sv
// instr_ptr_stack: instruction pointer with a return-address stack for zero-cycle call/ret
module instr_ptr_stack #(
  parameter int WIDTH = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               load_enable,
  input  logic [WIDTH-1:0]                   load_val,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               err_clear,
  output logic [WIDTH-1:0]                   ptr_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow_err,
  output logic                               underflow_err
);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [WIDTH-1:0] prev_val, prev_inc;
  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [SW-1:0] sp, top;
  logic pop, push;
  always_comb begin
    stack_depth = sp;
    stack_full = sp == SW'(STACK_DEPTH);
    stack_empty = sp == '0;
    top = sp - 1'b1;
    pop = ret && !stack_empty;
    push = call && !pop && !stack_full;
    ptr_out = pop ? stack[top[IW-1:0]] : (call || load_enable) ? load_val : enable ? prev_inc : prev_val;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_val <= '0;
      prev_inc <= WIDTH'(1);
      sp <= '0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      prev_val <= ptr_out;
      prev_inc <= ptr_out + 1'b1;
      sp <= push ? sp + 1'b1 : pop ? sp - 1'b1 : sp;
      overflow_err <= (call && !pop && stack_full) || (overflow_err && !err_clear);
      underflow_err <= (ret && stack_empty) || (underflow_err && !err_clear);
    end
  end
  // entries are never cleared; sp alone defines which are live
  always_ff @(posedge clk) begin
    if (!reset && push) stack[sp[IW-1:0]] <= prev_inc;
  end
endmodule

// File: tb/tb_instr_ptr_stack.sv
// tb_instr_ptr_stack: scoreboard bench comparing the DUT against a cycle model of the pointer/stack
module tb_instr_ptr_stack;
  logic clk = 1'b0;
  logic reset, enable, load_enable, call, ret, err_clear;
  logic [7:0] load_val, ptr_out;
  logic [2:0] stack_depth;
  logic stack_full, stack_empty, overflow_err, underflow_err;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0] ptr;
    logic [2:0] depth;
    logic full, empty, ovf, unf;
  } exp_t;
  exp_t sb[$];
  logic [7:0] m_val, m_inc;
  logic [7:0] m_stk [4];
  int m_sp;
  logic m_ovf, m_unf;
  instr_ptr_stack #(.WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_enable(load_enable), .load_val(load_val),
    .call(call), .ret(ret), .err_clear(err_clear), .ptr_out(ptr_out), .stack_depth(stack_depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic en, input logic ld, input logic c, input logic r, input logic ec,
                      input logic rs, input logic [7:0] lv);
    exp_t e;
    logic mpop, mpush;
    @(negedge clk);
    enable = en; load_enable = ld; call = c; ret = r; err_clear = ec; reset = rs; load_val = lv;
    mpop = r && m_sp != 0;
    e.ptr = mpop ? m_stk[m_sp-1] : (c || ld) ? lv : en ? m_inc : m_val;
    e.depth = 3'(m_sp);
    e.full = m_sp == 4;
    e.empty = m_sp == 0;
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("ptr", ptr_out, e.ptr);
    chk("depth", stack_depth, e.depth);
    chk("full", stack_full, e.full);
    chk("empty", stack_empty, e.empty);
    chk("ovf", overflow_err, e.ovf);
    chk("unf", underflow_err, e.unf);
    if (rs) begin
      m_val = 8'h00; m_inc = 8'h01; m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      mpush = c && !mpop && m_sp < 4;
      m_ovf = (c && !mpop && m_sp == 4) || (m_ovf && !ec);
      m_unf = (r && m_sp == 0) || (m_unf && !ec);
      if (mpush) begin
        m_stk[m_sp] = m_inc;
        m_sp++;
      end else if (mpop) m_sp--;
      m_val = e.ptr;
      m_inc = e.ptr + 8'h01;
    end
  endtask
  initial begin
    reset = 1'b1; enable = 1'b0; load_enable = 1'b0; call = 1'b0; ret = 1'b0; err_clear = 1'b0;
    load_val = 8'h00;
    repeat (2) @(posedge clk);
    m_val = 8'h00; m_inc = 8'h01; m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0;
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_ptr", ptr_out, 8'h00);
    chk("rst_empty", stack_empty, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 8'h00);
      chk("seq_ptr", ptr_out, 8'(i));
    end
    step(0, 1, 0, 0, 0, 0, 8'hff);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    chk("wrap", ptr_out, 8'h00);
    step(0, 1, 0, 0, 0, 0, 8'h10);
    step(0, 0, 1, 0, 0, 0, 8'h40);
    chk("call_jump", ptr_out, 8'h40);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    chk("call_depth", stack_depth, 3'd1);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 0, 8'h00);
    chk("ret_addr", ptr_out, 8'h11);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("ret_depth", stack_depth, 3'd0);
    step(0, 1, 0, 0, 0, 0, 8'h30);
    step(0, 0, 1, 0, 0, 0, 8'h50);
    step(0, 0, 1, 0, 0, 0, 8'h60);
    step(0, 0, 1, 0, 0, 0, 8'h70);
    step(0, 0, 1, 0, 0, 0, 8'h78);
    step(0, 0, 1, 0, 0, 0, 8'h80);
    chk("ovf_jump", ptr_out, 8'h80);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("ovf_flag", overflow_err, 1'b1);
    chk("ovf_depth", stack_depth, 3'd4);
    step(0, 0, 0, 1, 0, 0, 8'h00);
    chk("lifo0", ptr_out, 8'h71);
    step(0, 0, 0, 1, 0, 0, 8'h00);
    chk("lifo1", ptr_out, 8'h61);
    step(0, 0, 0, 1, 0, 0, 8'h00);
    chk("lifo2", ptr_out, 8'h51);
    step(0, 0, 0, 1, 0, 0, 8'h00);
    chk("lifo3", ptr_out, 8'h31);
    step(0, 0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("ovf_clr", overflow_err, 1'b0);
    step(0, 1, 0, 0, 0, 0, 8'h20);
    step(1, 0, 0, 1, 0, 0, 8'h00);
    chk("unf_adv", ptr_out, 8'h21);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("unf_flag", underflow_err, 1'b1);
    step(0, 0, 0, 1, 1, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("unf_set_wins", underflow_err, 1'b1);
    step(0, 0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("unf_clr", underflow_err, 1'b0);
    step(0, 1, 0, 0, 0, 0, 8'h04);
    step(0, 0, 1, 0, 0, 0, 8'h30);
    step(0, 1, 1, 1, 0, 0, 8'h99);
    chk("callret_ptr", ptr_out, 8'h05);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("callret_depth", stack_depth, 3'd0);
    step(0, 0, 1, 1, 0, 0, 8'h44);
    chk("callret_empty_ptr", ptr_out, 8'h44);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("callret_empty_depth", stack_depth, 3'd1);
    chk("callret_empty_unf", underflow_err, 1'b1);
    step(0, 0, 1, 0, 0, 0, 8'h55);
    step(0, 0, 1, 0, 0, 0, 8'h66);
    step(1, 1, 1, 1, 0, 1, 8'h77);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("mid_rst_ptr", ptr_out, 8'h00);
    chk("mid_rst_empty", stack_empty, 1'b1);
    chk("mid_rst_unf", underflow_err, 1'b0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           8'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
